// File: rtl/bram_port_adapter.sv
// Request/response front end for one port of a byte-enabled, write-first BRAM.
// Requests drive the BRAM pins combinationally; a tag pipe follows the BRAM's
// read latency and every output word lands in a small response FIFO. A credit
// counter covering in-flight plus queued responses guarantees the FIFO never
// overflows, so no BRAM output is ever dropped.
module bram_port_adapter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int WE_WIDTH   = 4,
    parameter int PIPELINED  = 0,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [WE_WIDTH-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_write,
    output logic                  bram_en,
    output logic [WE_WIDTH-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int LAT = (PIPELINED != 0) ? 2 : 1;
    localparam int PW  = $clog2(RSP_DEPTH);
    localparam int CW  = PW + 1;

    logic                  accept;
    logic                  pop;
    logic                  push;
    logic [CW-1:0]         cnt_reg;
    logic [CW-1:0]         cnt_next;
    logic                  tag_valid_reg [LAT];
    logic                  tag_write_reg [LAT];
    logic [DATA_WIDTH-1:0] fifo_data_reg [RSP_DEPTH];
    logic                  fifo_write_reg [RSP_DEPTH];
    logic [PW:0]           wr_ptr_reg;
    logic [PW:0]           rd_ptr_reg;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Handshakes; ready depends only on reset and the credit count.
    assign req_ready = !RST && (cnt_reg < CW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign push      = tag_valid_reg[LAT-1];

    // BRAM pins follow the request directly; writes only happen on accept.
    assign bram_en   = accept;
    assign bram_we   = (accept && req_write) ? req_wstrb : '0;
    assign bram_addr = req_addr;
    assign bram_din  = req_wdata;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                        (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);

    assign rsp_valid = !RST && !fifo_empty;
    assign rsp_rdata = fifo_data_reg[rd_ptr_reg[PW-1:0]];
    assign rsp_write = fifo_write_reg[rd_ptr_reg[PW-1:0]];

    // Credit update: accept takes a credit, pop returns one, both cancel.
    always_comb begin
        cnt_next = cnt_reg;
        if (accept && !pop) begin
            cnt_next = cnt_reg + CW'(1);
        end else if (!accept && pop) begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    // Credit counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // First tag stage captures the accepted request's kind.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_valid_reg[0] <= 1'b0;
            tag_write_reg[0] <= 1'b0;
        end else begin
            tag_valid_reg[0] <= accept;
            tag_write_reg[0] <= req_write;
        end
    end

    // Remaining tag stages track the BRAM output register pipeline.
    for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
        always_ff @(posedge CLK) begin
            if (RST) begin
                tag_valid_reg[gi] <= 1'b0;
                tag_write_reg[gi] <= 1'b0;
            end else begin
                tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                tag_write_reg[gi] <= tag_write_reg[gi-1];
            end
        end
    end

    // FIFO storage: capture the BRAM word when its tag reaches the last stage.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            fifo_data_reg[wr_ptr_reg[PW-1:0]]  <= bram_dout;
            fifo_write_reg[wr_ptr_reg[PW-1:0]] <= tag_write_reg[LAT-1];
        end
    end

    // FIFO pointers; push and pop proceed independently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // The credit scheme must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge CLK) disable iff (RST) push |-> !fifo_full);
`endif

endmodule

// File: tb/tb_bram_port_adapter.sv
// Bench for bram_port_adapter: one instance per read latency (PIPELINED=0/1),
// each attached to a behavioural write-first BRAM. A shadow memory plus an
// ordered queue of expected responses predicts every output cycle by cycle.
module tb_bram_port_adapter;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int WW    = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          w;
        int            t;
    } exp_t;

    logic clk = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [DW-1:0] preload(input int i);
        if (i == 5) return 32'hDEADBEEF;
        if (i == 3) return 32'hAABBCCDD;
        return (32'(i) * 32'h9E3779B1) ^ 32'h12345678;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = gi + 1;

        logic          rst;
        logic          req_valid, req_ready, req_write;
        logic [AW-1:0] req_addr;
        logic [DW-1:0] req_wdata;
        logic [WW-1:0] req_wstrb;
        logic          rsp_valid, rsp_ready, rsp_write;
        logic [DW-1:0] rsp_rdata;
        logic          bram_en;
        logic [WW-1:0] bram_we;
        logic [AW-1:0] bram_addr;
        logic [DW-1:0] bram_din, bram_dout;
        logic          done = 1'b0;

        bram_port_adapter #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
            .PIPELINED(gi), .RSP_DEPTH(DEPTH)
        ) dut (
            .CLK(clk), .RST(rst),
            .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
            .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
            .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
            .rsp_rdata(rsp_rdata), .rsp_write(rsp_write),
            .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
            .bram_din(bram_din), .bram_dout(bram_dout)
        );

        // Behavioural write-first byte-enabled BRAM with 1 or 2 output registers.
        logic [DW-1:0] bmem [1 << AW];
        logic [DW-1:0] do1, do2;
        always @(posedge clk) begin
            automatic logic [DW-1:0] w;
            if (bram_en) begin
                w = bmem[bram_addr];
                for (int b = 0; b < WW; b++)
                    if (bram_we[b]) w[b*8 +: 8] = bram_din[b*8 +: 8];
                bmem[bram_addr] <= w;
                do1 <= w;
            end
            do2 <= do1;
        end
        assign bram_dout = (LAT == 1) ? do1 : do2;

        // Reference state.
        logic [DW-1:0] ref_mem [1 << AW];
        exp_t          q[$];
        int            cyc = 0;
        int            last_pop = -100;
        int            acc_count = 0;
        logic [DW-1:0] last_data = '0;

        initial begin
            for (int i = 0; i < (1 << AW); i++) begin
                bmem[i]    = preload(i);
                ref_mem[i] = preload(i);
            end
        end

        function automatic string tg(input string s);
            return $sformatf("L%0d_%s", LAT, s);
        endfunction

        // Cycle monitor: checks the current cycle, then applies its accept/pop.
        always @(negedge clk) begin
            automatic logic          acc;
            automatic int            due;
            automatic logic [DW-1:0] m;
            if (rst) begin
                check(tg("rst_req_ready"), req_ready, 0);
                check(tg("rst_bram_en"), bram_en, 0);
                check(tg("rst_bram_we"), bram_we, 0);
                check(tg("rst_rsp_valid"), rsp_valid, 0);
                q.delete();
                last_pop = -100;
            end else begin
                check(tg("req_ready"), req_ready, (q.size() < DEPTH) ? 1 : 0);
                acc = req_valid && req_ready;
                check(tg("bram_en"), bram_en, acc);
                check(tg("bram_we"), bram_we, (acc && req_write) ? req_wstrb : 4'b0);
                check(tg("bram_addr"), bram_addr, req_addr);
                check(tg("bram_din"), bram_din, req_wdata);
                if (q.size() == 0) begin
                    check(tg("rsp_valid_idle"), rsp_valid, 0);
                end else begin
                    due = q[0].t + LAT + 1;
                    if (last_pop + 1 > due) due = last_pop + 1;
                    check(tg("rsp_valid"), rsp_valid, (cyc >= due) ? 1 : 0);
                    if (rsp_valid) begin
                        check(tg("rsp_rdata"), rsp_rdata, q[0].d);
                        check(tg("rsp_write"), rsp_write, q[0].w);
                        if (rsp_ready) begin
                            last_data = rsp_rdata;
                            void'(q.pop_front());
                            last_pop = cyc;
                        end
                    end
                end
                if (acc) begin
                    m = ref_mem[req_addr];
                    if (req_write) begin
                        for (int b = 0; b < WW; b++)
                            if (req_wstrb[b]) m[b*8 +: 8] = req_wdata[b*8 +: 8];
                        ref_mem[req_addr] = m;
                    end
                    q.push_back('{d: m, w: req_write, t: cyc});
                    acc_count++;
                end
            end
            cyc++;
        end

        task automatic issue(input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [WW-1:0] s);
            int guard;
            guard = 0;
            req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
            @(negedge clk);
            while (!req_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) check(tg("issue_timeout"), guard, 0);
            @(posedge clk); #1;
            req_valid = 1'b0;
        endtask

        task automatic drain();
            int guard;
            guard = 0;
            rsp_ready = 1'b1;
            while (q.size() != 0 && guard < 200) begin
                @(posedge clk);
                guard++;
            end
            @(posedge clk); #1;
            check(tg("drain"), q.size(), 0);
        endtask

        initial begin
            int            i;
            int            guard;
            int            acc_base;
            logic          acc;
            rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
            req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;

            // Single read of a preloaded word.
            issue(1'b0, 8'd5, '0, '0);
            drain();
            check(tg("read5"), last_data, 32'hDEADBEEF);

            // Partial write: write-first response, then read back.
            issue(1'b1, 8'd3, 32'h11223344, 4'b0101);
            drain();
            check(tg("wr3_rsp"), last_data, 32'hAA22CC44);
            issue(1'b0, 8'd3, '0, '0);
            drain();
            check(tg("rd3"), last_data, 32'hAA22CC44);

            // Back-pressure: exactly DEPTH accepts with the consumer stalled.
            rsp_ready = 1'b0;
            acc_base = acc_count;
            req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd10;
            repeat (10) @(posedge clk);
            #1 req_valid = 1'b0;
            check(tg("bp_accepts"), acc_count - acc_base, DEPTH);
            drain();

            // Accept and pop in the same cycle with three credits used.
            rsp_ready = 1'b0;
            issue(1'b0, 8'd20, '0, '0);
            issue(1'b0, 8'd21, '0, '0);
            issue(1'b0, 8'd22, '0, '0);
            repeat (4) @(posedge clk);
            #1;
            req_valid = 1'b1; req_addr = 8'd23; rsp_ready = 1'b1;
            @(negedge clk);
            check(tg("sim_ready"), req_ready, 1);
            check(tg("sim_rsp_valid"), rsp_valid, 1);
            @(posedge clk); #1;
            req_valid = 1'b0; rsp_ready = 1'b0;
            @(negedge clk);
            check(tg("sim_ready_after"), req_ready, 1);
            @(posedge clk); #1;
            drain();

            // Streaming reads of 0..63 with random consumer stalls.
            i = 0; guard = 0;
            while (i < 64 && guard < 2000) begin
                req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(i);
                rsp_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                acc = req_ready;
                @(posedge clk); #1;
                if (acc) i++;
                guard++;
            end
            req_valid = 1'b0;
            check(tg("stream_count"), i, 64);
            drain();

            // Random mix of reads and partial writes on a small address window.
            repeat (200) begin
                req_valid = $urandom_range(0, 1);
                req_write = $urandom_range(0, 1);
                req_addr  = AW'($urandom_range(0, 15));
                req_wdata = $urandom;
                req_wstrb = WW'($urandom_range(0, 15));
                rsp_ready = ($urandom_range(0, 2) != 0);
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            drain();

            // Reset with responses outstanding; the committed write must survive.
            rsp_ready = 1'b0;
            issue(1'b1, 8'd7, 32'hCAFEF00D, 4'hF);
            issue(1'b0, 8'd1, '0, '0);
            issue(1'b0, 8'd2, '0, '0);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check(tg("post_rst_valid"), rsp_valid, 0);
            check(tg("post_rst_ready"), req_ready, 1);
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            issue(1'b0, 8'd7, '0, '0);
            drain();
            check(tg("post_rst_read"), last_data, 32'hCAFEF00D);

            done = 1'b1;
        end
    end

    initial begin
        int n_done;
        for (int k = 0; k < 40000 && !(g_inst[0].done && g_inst[1].done); k++)
            @(posedge clk);
        n_done = int'(g_inst[0].done) + int'(g_inst[1].done);
        check("all_done", n_done, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
